// File: rtl/pc_fetch_unit.sv
// Purpose : instruction-fetch stage; holds the PC, fetches over req/ack and picks next PC from decoder controls.
// Latency : >= 2 cycles per instruction (WAIT with immediate ack, then one EXEC cycle).
// Backpressure: unbounded imem_ack delay holds WAIT; hold=1 freezes EXEC (pc/instr/instr_valid stable).
//
// Ports:
//   clk, reset_n          - rising-edge clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata - instruction memory handshake; imem_addr always equals pc
//   instr, instr_valid    - captured instruction and its execute window
//   pc, pcplus4           - current instruction address and pc + 4
//   branch, jump, zero, signimm, hold - decoder/datapath controls, sampled only in EXEC
// Optional: define PC_FETCH_PERF_CNT_EN to add retired_cnt / stall_cnt outputs.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    input  logic [31:0] signimm,
`ifdef PC_FETCH_PERF_CNT_EN
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt,
`endif
    input  logic        hold
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;

    logic [1:0]  state;
    logic [31:0] next_pc;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;

    assign pcplus4   = pc + 32'd4;
    assign imem_addr = pc;

    // Jump keeps the region bits of pc+4; branch offset is a word count, carry out is dropped.
    assign jump_tgt   = {pcplus4[31:28], instr[25:0], 2'b00};
    assign branch_tgt = pcplus4 + {signimm[29:0], 2'b00};

    always_comb begin
        next_pc = pcplus4;
        if (jump) begin
            next_pc = jump_tgt;
        end else if (branch && zero) begin
            next_pc = branch_tgt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    imem_req <= 1'b1;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!hold) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= ST_WAIT;
                    end
                end
                default: begin
                    state       <= ST_FETCH;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_cnt <= 32'd0;
            stall_cnt   <= 32'd0;
        end else begin
            if (state == ST_EXEC && !hold) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
            if ((state == ST_WAIT && !imem_ack) || (state == ST_EXEC && hold)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        branch;
    logic        jump;
    logic        zero;
    logic [31:0] signimm;
    logic        hold;
`ifdef PC_FETCH_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pcplus4    (pcplus4),
        .branch     (branch),
        .jump       (jump),
        .zero       (zero),
        .signimm    (signimm),
`ifdef PC_FETCH_PERF_CNT_EN
        .retired_cnt(retired_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .hold       (hold)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard whenever a transfer or execute window is visible.
    logic        prev_req, prev_vld;
    logic [31:0] prev_addr, prev_instr, prev_pc;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_req = 1'b0;
            prev_vld = 1'b0;
        end else begin
            if (imem_req) chk("no_valid_in_wait", {31'd0, instr_valid}, 32'd0);
            if (imem_req && prev_req) chk("addr_stable", imem_addr, prev_addr);
            if (imem_req && imem_ack) begin
                if (exp_q.size() == 0) chk("unexpected_fetch", imem_addr, 32'hDEAD_BEEF);
                else                   chk("fetch_addr", imem_addr, exp_q[0].addr);
            end
            if (instr_valid && !prev_vld) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", instr, 32'hDEAD_BEEF);
                end else begin
                    chk("instr", instr, exp_q[0].word);
                    chk("exec_pc", pc, exp_q[0].addr);
                    void'(exp_q.pop_front());
                end
            end
            if (instr_valid && prev_vld) begin
                chk("hold_instr", instr, prev_instr);
                chk("hold_pc", pc, prev_pc);
            end
            prev_req   = imem_req;
            prev_addr  = imem_addr;
            prev_vld   = instr_valid;
            prev_instr = instr;
            prev_pc    = pc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one fetch at address a with `lat` idle WAIT cycles, then run EXEC with the given controls.
    task automatic do_instr(input logic [31:0] a, input logic [31:0] w, input int lat,
                            input logic br, input logic jp, input logic z,
                            input logic [31:0] imm, input int hc);
        exp_t e;
        int n = 0;
        while (!imem_req && n < 50) begin
            tick();
            n++;
        end
        if (!imem_req) begin
            chk("req_timeout", {31'd0, imem_req}, 32'd1);
            return;
        end
        imem_ack = 1'b0;
        for (int i = 0; i < lat; i++) tick();
        e.addr = a;
        e.word = w;
        exp_q.push_back(e);
        imem_ack   = 1'b1;
        imem_rdata = w;
        branch     = br;
        jump       = jp;
        zero       = z;
        signimm    = imm;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
        hold = (hc > 0);
        for (int i = 0; i < hc; i++) tick();
        hold = 1'b0;
        tick();
        chk("valid_drop", {31'd0, instr_valid}, 32'd0);
        chk("req_rearm", {31'd0, imem_req}, 32'd1);
        branch  = 1'b0;
        jump    = 1'b0;
        zero    = 1'b0;
        signimm = 32'd0;
    endtask

    initial begin
        reset_n    = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        branch     = 1'b0;
        jump       = 1'b0;
        zero       = 1'b0;
        signimm    = 32'd0;
        hold       = 1'b0;

        repeat (3) tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        reset_n = 1'b1;
        tick();
        tick();
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);

        // a, word, lat, br, jp, z, imm, hold cycles -> hand-computed next address is the next call's a
        do_instr(32'h0000_0000, 32'h2001_0001, 0, 0, 0, 0, 32'h0, 0);
        do_instr(32'h0000_0004, 32'h2002_0002, 0, 0, 0, 0, 32'h0, 0);
        do_instr(32'h0000_0008, 32'h2003_0003, 3, 0, 0, 0, 32'h0, 0);
        do_instr(32'h0000_000C, 32'h0000_0020, 0, 0, 0, 0, 32'h0, 0);
        do_instr(32'h0000_0010, 32'h1000_FFFF, 0, 1, 0, 1, 32'hFFFF_FFFF, 0);
        do_instr(32'h0000_0010, 32'h1000_FFFF, 0, 1, 0, 0, 32'hFFFF_FFFF, 0);
        do_instr(32'h0000_0014, 32'h1000_0002, 1, 1, 0, 1, 32'h0000_0002, 0);
        do_instr(32'h0000_0020, 32'h0800_0040, 0, 1, 1, 1, 32'h0000_0005, 0);
        do_instr(32'h0000_0100, 32'h2004_0004, 0, 0, 0, 0, 32'h0, 5);
        do_instr(32'h0000_0104, 32'h1000_FFBD, 2, 1, 0, 1, 32'hFFFF_FFBD, 0);
        do_instr(32'hFFFF_FFFC, 32'h2005_0005, 0, 0, 0, 0, 32'h0, 0);
        do_instr(32'h0000_0000, 32'h2006_0006, 0, 0, 0, 0, 32'h0, 0);
        chk("seq_addr_after_wrap", imem_addr, 32'h0000_0004);

        // Reset in the middle of WAIT for 0x4: request must drop without a clock edge.
        tick();
        tick();
        #1;
        reset_n = 1'b0;
        #1;
        chk("midwait_req_drop", {31'd0, imem_req}, 32'd0);
        chk("midwait_pc", pc, 32'h0);
        chk("midwait_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        reset_n    = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_0000;
        tick();
        imem_ack   = 1'b0;
        chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        chk("late_ack_instr", instr, 32'h0);
        chk("late_ack_pc", pc, 32'h0);
        chk("late_ack_req", {31'd0, imem_req}, 32'd1);
        do_instr(32'h0000_0000, 32'h2007_0007, 0, 0, 0, 0, 32'h0, 0);
        chk("final_addr", imem_addr, 32'h0000_0004);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time %0t reached, expected test end", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main/ALU decoders in the single-cycle MIPS core.
- Holds the PC and fetches each instruction from a variable-latency instruction memory using a req/ack handshake.
- Presents the instruction to the decoder for one execute window, then selects the next PC from the decoder's branch/jump controls and the ALU zero flag.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction memory request, held until ack.
- imem_addr  out  32  instruction memory byte address (always equals pc).
- imem_ack  in  1  memory accepted request; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word from memory.
- instr  out  32  captured instruction to decoder; instr[31:26] is the opcode.
- instr_valid  out  1  instr valid; decoder controls are honoured only while high.
- pc  out  32  address of the current instruction.
- pcplus4  out  32  pc + 4, combinational.
- branch  in  1  decoder branch control.
- jump  in  1  decoder jump control.
- zero  in  1  ALU zero flag for the current instruction.
- signimm  in  32  sign-extended immediate for the current instruction.
- hold  in  1  downstream stall; freezes the EXEC state.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State = FETCH, pc = RESET_PC.
  - imem_req = 0, instr = 0, instr_valid = 0.
  - Outputs change immediately, without waiting for a clock edge.
- FETCH: one cycle after reset release; set imem_req = 1 (registered) and go to WAIT.
- WAIT:
  - imem_req = 1; imem_addr stable.
  - On imem_ack = 1: instr <= imem_rdata, instr_valid <= 1, imem_req <= 0, go to EXEC.
  - Without ack: stay in WAIT; wait length is unbounded.
- EXEC:
  - instr_valid = 1. The decoder plus datapath combinationally return branch, jump, zero and signimm.
  - If hold = 1: stay in EXEC; pc, instr and instr_valid are stable.
  - If hold = 0: pc <= next_pc, instr_valid <= 0, imem_req <= 1, go to WAIT.
- Throughput: minimum 2 cycles per instruction (WAIT with immediate ack, then EXEC).
- next_pc priority:
  - jump: {pcplus4[31:28], instr[25:0], 2'b00}.
  - else branch & zero: pcplus4 + (signimm << 2), 32-bit wrap-around, carry discarded.
  - else: pcplus4.
- jump and branch both high: jump wins.
- pcplus4 wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- imem_ack outside WAIT is ignored, including a late ack after reset.
- Reset mid-WAIT or mid-EXEC:
  - Request abandoned and imem_req drops asynchronously.
  - Any instruction in flight is discarded; no PC update.
- branch, jump, zero, signimm and hold are sampled only in EXEC.

Optional Feature:
- Macro: PC_FETCH_PERF_CNT_EN.
- When defined, the block adds two outputs, each reset to 0 and wrapping at 2^32:
  - retired_cnt (32 bit): increments on every EXEC exit with hold = 0.
  - stall_cnt (32 bit): increments on every WAIT cycle without ack and every EXEC cycle with hold = 1.
- When undefined: the ports and counters are absent, and there is no other change in behaviour.

Test Plan:
- Reset: hold reset_n low 3 cycles, then release -> pc = 0, instr_valid = 0, imem_req = 0 during reset; imem_req = 1 and imem_addr = 0 two cycles after release.
- Sequential fetch, zero-latency ack, no branch or jump:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - instr_valid pulses 1 cycle in every 2.
- Memory latency: ack delayed 3 cycles -> imem_req and imem_addr stable for all 4 WAIT cycles; instr captured only on the ack cycle.
- Taken BEQ: pc = 0x10, branch = 1, zero = 1, signimm = 0xFFFFFFFF -> next imem_addr = 0x14 - 4 = 0x10. Same case with zero = 0 -> 0x14.
- Jump: pc = 0x20, instr = 0x08000040, jump = 1, branch = 1 -> next pc = 0x00000100 (jump wins).
- Stall and reset:
  - hold = 1 for 5 EXEC cycles -> pc and instr unchanged; a single advance after hold falls.
  - reset_n pulsed low mid-WAIT -> imem_req drops immediately.
  - A subsequent ack is ignored, and pc = RESET_PC.
